// File: rtl/bus_arbiter_pkg.sv
// Processor-wide datapath definitions shared by the bus arbiter and its users.
// Provides the arbiter state encoding, bus width, default register file
// sizing and register index constants, plus an index-width helper.
package bus_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int unsigned BUS_W         = 24;
  localparam int unsigned N_REG_DEFAULT = 8;
  localparam int unsigned REG_IDX_W     = 3;
  localparam int unsigned AC_IDX        = 0;
  localparam int unsigned R1_IDX        = 1;

  // Width of an index able to address n items (minimum 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational masked round-robin picker.
// Ports:
//   elig  - eligible requesters
//   ptr   - highest-priority index; search wraps modulo N
//   win   - one-hot winner (zero when nothing is eligible)
//   valid - any requester eligible
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = idx_w(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);

  // Scan offsets 0..N-1 from ptr; first eligible hit wins.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!valid && elig[i] && (((32'(ptr) + off) % N) == i)) begin
          win[i] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Internal data bus arbiter: grants one requester per cycle a single
// register-to-register transfer, round-robin with bounded locked bursts.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req, lock           - per-requester request / back-to-back re-grant request
//   src_idx, dst_idx    - per-requester register indices (slice i = [i*REG_W +: REG_W])
//   dst_en              - per-requester destination write enable
//   gnt, done           - registered one-hot grant and coincident done pulse
//   bus_rd_en           - one-hot-or-zero register bus-read enables
//   reg_wr_en           - one-hot-or-zero register write strobes
//   err                 - granted index out of range
//   busy                - transfer in progress
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned N_REG    = N_REG_DEFAULT,
  parameter int unsigned REG_W    = REG_IDX_W,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*REG_W-1:0] src_idx,
  input  logic [N_REQ*REG_W-1:0] dst_idx,
  input  logic [N_REQ-1:0]       dst_en,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [N_REG-1:0]       bus_rd_en,
  output logic [N_REG-1:0]       reg_wr_en,
  output logic                   err,
  output logic                   busy
);

  localparam int unsigned PW  = idx_w(N_REQ);
  localparam int unsigned LCW = idx_w(MAX_LOCK + 1);

  arb_state_t       state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    cur_q, cur_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;

  logic [N_REQ-1:0] elig, rr_win, win;
  logic             rr_valid, relock, any;
  logic [PW-1:0]    win_idx;
  logic [REG_W-1:0] sel_src, sel_dst;
  logic             sel_den, src_ok, dst_ok;

  logic [N_REQ-1:0] gnt_d;
  logic [N_REG-1:0] rd_d, wr_d;
  logic             err_d;

  // Mask the requester being served now unless it may keep a locked burst.
  always_comb begin
    relock = 1'b0;
    elig   = req;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if ((state_q == XFER) && (cur_q == PW'(i))) begin
        relock = req[i] && lock[i] && (32'(lock_cnt_q) < MAX_LOCK);
        if (!relock) begin
          elig[i] = 1'b0;
        end
      end
    end
  end

  bus_arbiter_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_pick (
    .elig  (elig),
    .ptr   (rr_ptr_q),
    .win   (rr_win),
    .valid (rr_valid)
  );

  // Next state, bookkeeping and next registered outputs.
  always_comb begin
    state_d    = IDLE;
    rr_ptr_d   = rr_ptr_q;
    cur_d      = cur_q;
    lock_cnt_d = lock_cnt_q;
    gnt_d      = '0;
    rd_d       = '0;
    wr_d       = '0;
    err_d      = 1'b0;
    sel_src    = '0;
    sel_dst    = '0;
    sel_den    = 1'b0;
    win_idx    = '0;

    // Locked re-grant bypasses the round-robin choice.
    win = relock ? (N_REQ'(1) << cur_q) : rr_win;
    any = relock || rr_valid;

    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx = PW'(i);
        sel_src = src_idx[i*REG_W +: REG_W];
        sel_dst = dst_idx[i*REG_W +: REG_W];
        sel_den = dst_en[i];
      end
    end

    src_ok = (32'(sel_src) < N_REG);
    dst_ok = (32'(sel_dst) < N_REG);

    if (any) begin
      state_d    = XFER;
      gnt_d      = win;
      cur_d      = win_idx;
      rr_ptr_d   = (32'(win_idx) == (N_REQ - 1)) ? '0 : win_idx + PW'(1);
      lock_cnt_d = relock ? lock_cnt_q + LCW'(1) : LCW'(1);
      err_d      = !src_ok || (sel_den && !dst_ok);
      for (int unsigned r = 0; r < N_REG; r++) begin
        rd_d[r] = src_ok && (32'(sel_src) == r);
        wr_d[r] = sel_den && dst_ok && (32'(sel_dst) == r);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cur_q      <= '0;
      lock_cnt_q <= '0;
      gnt        <= '0;
      done       <= '0;
      bus_rd_en  <= '0;
      reg_wr_en  <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_q      <= cur_d;
      lock_cnt_q <= lock_cnt_d;
      gnt        <= gnt_d;
      done       <= gnt_d;
      bus_rd_en  <= rd_d;
      reg_wr_en  <= wr_d;
      err        <= err_d;
      busy       <= (state_d == XFER);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter with an expected-output scoreboard.
module tb_bus_arbiter;

  localparam int unsigned NQ = 3;
  localparam int unsigned NR = 8;
  localparam int unsigned RW = 4;

  logic              clk;
  logic              reset;
  logic [NQ-1:0]     req, lock, dst_en;
  logic [NQ*RW-1:0]  src_idx, dst_idx;
  logic [NQ-1:0]     gnt, done;
  logic [NR-1:0]     bus_rd_en, reg_wr_en;
  logic              err, busy;

  typedef struct {
    string         tag;
    logic [NQ-1:0] g;
    logic [NR-1:0] rd;
    logic [NR-1:0] wr;
    logic          e;
  } exp_t;

  exp_t        sb[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  bus_arbiter #(
    .N_REQ    (NQ),
    .N_REG    (NR),
    .REG_W    (RW),
    .MAX_LOCK (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .src_idx   (src_idx),
    .dst_idx   (dst_idx),
    .dst_en    (dst_en),
    .gnt       (gnt),
    .done      (done),
    .bus_rd_en (bus_rd_en),
    .reg_wr_en (reg_wr_en),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input string tag, input logic [NQ-1:0] g,
                      input logic [NR-1:0] rd, input logic [NR-1:0] wr,
                      input logic e);
    exp_t x;
    x.tag = tag; x.g = g; x.rd = rd; x.wr = wr; x.e = e;
    sb.push_back(x);
  endtask

  // Advance one cycle, then compare the DUT outputs to the oldest expectation.
  task automatic tick();
    exp_t        x;
    logic [23:0] obs, expv;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      x    = sb.pop_front();
      obs  = {gnt, done, bus_rd_en, reg_wr_en, err, busy};
      expv = {x.g, x.g, x.rd, x.wr, x.e, |x.g};
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed gnt=%b done=%b rd=%h wr=%h err=%b busy=%b, expected gnt=%b done=%b rd=%h wr=%h err=%b busy=%b",
                  x.tag, gnt, done, bus_rd_en, reg_wr_en, err, busy,
                  x.g, x.g, x.rd, x.wr, x.e, |x.g);
      total++;
      assert ($onehot0(bus_rd_en)) passed++;
      else $error("FAIL %s_onehot: bus_rd_en=%h, expected at most one bit set", x.tag, bus_rd_en);
    end
  endtask

  task automatic set_cmd(input int unsigned i, input int unsigned s,
                         input int unsigned d, input logic den);
    src_idx[i*RW +: RW] = RW'(s);
    dst_idx[i*RW +: RW] = RW'(d);
    dst_en[i]           = den;
  endtask

  // One requester alone: grant cycle, then the masked cycle after done.
  task automatic solo(input string tag, input int unsigned i,
                      input int unsigned s, input int unsigned d, input logic den,
                      input logic [NR-1:0] rd, input logic [NR-1:0] wr,
                      input logic e);
    set_cmd(i, s, d, den);
    req = NQ'(1) << i;
    push(tag, NQ'(1) << i, rd, wr, e);
    tick();
    push({tag, "_mask"}, '0, '0, '0, 1'b0);
    tick();
    req = '0;
  endtask

  initial begin
    reset = 1'b1; req = '0; lock = '0; dst_en = '0; src_idx = '0; dst_idx = '0;
    push("reset0", '0, '0, '0, 1'b0); tick();
    push("reset1", '0, '0, '0, 1'b0); tick();
    reset = 1'b0;

    // Basic transfer R2 -> AC.
    solo("basic", 0, 2, 0, 1'b1, 8'h04, 8'h01, 1'b0);
    push("basic_idle", '0, '0, '0, 1'b0); tick();

    // Index range boundaries on requester 2.
    solo("src7",      2, 7, 3,  1'b1, 8'h80, 8'h08, 1'b0);
    solo("dst9",      2, 7, 9,  1'b1, 8'h80, 8'h00, 1'b1);
    solo("src10",     2, 10, 3, 1'b1, 8'h00, 8'h08, 1'b1);
    solo("dst12_rdo", 2, 1, 12, 1'b0, 8'h02, 8'h00, 1'b0);

    set_cmd(0, 2, 0, 1'b1);
    set_cmd(1, 3, 1, 1'b1);
    set_cmd(2, 5, 6, 1'b0);

    // Locked burst: four grants to requester 1, then requester 0.
    req = 3'b010; lock = 3'b010;
    push("lock_first", 3'b010, 8'h08, 8'h02, 1'b0); tick();
    req = 3'b011;
    for (int k = 0; k < 3; k++) begin
      push("lock_regrant", 3'b010, 8'h08, 8'h02, 1'b0); tick();
    end
    push("lock_release", 3'b001, 8'h04, 8'h01, 1'b0); tick();
    req = '0; lock = '0;
    push("lock_idle", '0, '0, '0, 1'b0); tick();

    // Single unlocked requester, read-only: granted every other cycle.
    req = 3'b100;
    for (int k = 0; k < 3; k++) begin
      push("single_gnt", 3'b100, 8'h20, 8'h00, 1'b0); tick();
      push("single_gap", '0, '0, '0, 1'b0); tick();
    end
    req = '0;

    // Reset during a transfer, then full round-robin from pointer 0.
    req = 3'b010;
    push("pre_reset", 3'b010, 8'h08, 8'h02, 1'b0); tick();
    reset = 1'b1; req = 3'b111;
    push("reset_xfer", '0, '0, '0, 1'b0); tick();
    reset = 1'b0;
    push("rr0", 3'b001, 8'h04, 8'h01, 1'b0); tick();
    push("rr1", 3'b010, 8'h08, 8'h02, 1'b0); tick();
    push("rr2", 3'b100, 8'h20, 8'h00, 1'b0); tick();
    push("rr3", 3'b001, 8'h04, 8'h01, 1'b0); tick();
    req = '0;
    push("final_idle", '0, '0, '0, 1'b0); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
